// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared 8259A constants and types
package pic_pkg;

  localparam logic [2:0] NSEOI     = 3'b001;
  localparam logic [2:0] SEOI      = 3'b011;
  localparam logic [2:0] ROT_NSEOI = 3'b101;
  localparam logic [2:0] ROT_SEOI  = 3'b111;

  localparam int AEOI_BIT = 1;

  typedef logic [2:0] level_t;

endpackage

// File: rtl/isr_priority_scan.sv
// rtl/isr_priority_scan.sv - finds highest-priority set ISR bit, searching upward from base
module isr_priority_scan
  import pic_pkg::*;
(
  input  logic [7:0] isr,
  input  level_t     base,
  output level_t     index,
  output logic       found
);

  always_comb begin
    index = '0;
    found = |isr;
    // walk from lowest priority to highest so the last hit is the winner
    for (int i = 7; i >= 0; i--) begin
      if (isr[base + level_t'(i)]) index = base + level_t'(i);
    end
  end

endmodule

// File: rtl/in_service_register.sv
// rtl/in_service_register.sv - 8259A in-service register with AEOI/EOI clearing and vector output
// Specific EOI (OCW2 codes 011/111) is only honoured when ISR_SPECIFIC_EOI_EN is defined.
module in_service_register
  import pic_pkg::*;
#(
  parameter int NUM_LEVELS = 8
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            toSet,
  input  logic                  readPriority,
  input  logic                  readIsr,
  input  logic                  sendVector,
  input  logic [2:0]            zeroLevelIndex,
  input  logic [7:0]            ICW2,
  input  logic [7:0]            ICW4,
  input  logic [7:0]            OCW2,
  input  logic                  secondACK,
  input  logic                  changeInOCW2,
  output logic [2:0]            INTIndex,
  output logic [7:0]            dataBuffer,
  output logic [NUM_LEVELS-1:0] isrRegValue,
  output logic [2:0]            resetedIndex,
  output logic                  resetedValid
);

  logic [NUM_LEVELS-1:0] isr, isr_next, set_mask, clr_mask;
  level_t scan_index, clr_index;
  logic scan_found, aeoi_hit, nseoi_hit, seoi_hit;
  logic [2:0] cmd;
  logic unused_bits;

  assign unused_bits = ^{ICW2[2:0], ICW4[7:2], ICW4[0], OCW2[4:3]};

  isr_priority_scan u_scan (
    .isr   (isr),
    .base  (zeroLevelIndex),
    .index (scan_index),
    .found (scan_found)
  );

  always_comb begin
    cmd       = OCW2[7:5];
    aeoi_hit  = secondACK && ICW4[AEOI_BIT] && isr[INTIndex];
    nseoi_hit = changeInOCW2 && (cmd == NSEOI || cmd == ROT_NSEOI) && scan_found;
`ifdef ISR_SPECIFIC_EOI_EN
    seoi_hit  = changeInOCW2 && (cmd == SEOI || cmd == ROT_SEOI) && isr[OCW2[2:0]];
`else
    seoi_hit  = 1'b0;
`endif
    set_mask = '0;
    if (readPriority) set_mask[toSet] = 1'b1;
    clr_mask = '0;
    if (aeoi_hit)  clr_mask[INTIndex]   = 1'b1;
    if (nseoi_hit) clr_mask[scan_index] = 1'b1;
    if (seoi_hit)  clr_mask[OCW2[2:0]]  = 1'b1;
    // a simultaneous set of the same level cancels its clear
    clr_mask = clr_mask & ~set_mask;
    isr_next = (isr & ~clr_mask) | set_mask;
    if (aeoi_hit && !set_mask[INTIndex])
      clr_index = INTIndex;
    else if (nseoi_hit && !set_mask[scan_index])
      clr_index = scan_index;
    else
      clr_index = OCW2[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr          <= '0;
      INTIndex     <= '0;
      resetedIndex <= '0;
      resetedValid <= 1'b0;
    end else begin
      isr          <= isr_next;
      resetedValid <= |clr_mask;
      if (readPriority) INTIndex     <= toSet;
      if (|clr_mask)    resetedIndex <= clr_index;
    end
  end

  always_comb begin
    if (sendVector)   dataBuffer = {ICW2[7:3], INTIndex};
    else if (readIsr) dataBuffer = isr;
    else              dataBuffer = 8'h00;
  end

  assign isrRegValue = isr;

endmodule

// File: tb/tb_in_service_register.sv
// tb/tb_in_service_register.sv - table-driven self-checking bench for in_service_register
module tb_in_service_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] toSet, zeroLevelIndex;
  logic       readPriority, readIsr, sendVector, secondACK, changeInOCW2;
  logic [7:0] ICW2, ICW4, OCW2;
  logic [2:0] INTIndex, resetedIndex;
  logic [7:0] dataBuffer, isrRegValue;
  logic       resetedValid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] ts;
    logic       rp, ri, sv;
    logic [2:0] zli;
    logic [7:0] icw4, ocw2;
    logic       sack, chg;
    logic [7:0] e_isr;
    logic [2:0] e_int, e_ridx;
    logic       e_rv;
    logic [7:0] e_db;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  in_service_register dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .toSet          (toSet),
    .readPriority   (readPriority),
    .readIsr        (readIsr),
    .sendVector     (sendVector),
    .zeroLevelIndex (zeroLevelIndex),
    .ICW2           (ICW2),
    .ICW4           (ICW4),
    .OCW2           (OCW2),
    .secondACK      (secondACK),
    .changeInOCW2   (changeInOCW2),
    .INTIndex       (INTIndex),
    .dataBuffer     (dataBuffer),
    .isrRegValue    (isrRegValue),
    .resetedIndex   (resetedIndex),
    .resetedValid   (resetedValid)
  );

  function automatic vec_t mk(input logic [2:0] ts, input logic rp, ri, sv,
                              input logic [2:0] zli, input logic [7:0] icw4, ocw2,
                              input logic sack, chg, input logic [7:0] e_isr,
                              input logic [2:0] e_int, e_ridx, input logic e_rv,
                              input logic [7:0] e_db);
    vec_t v;
    v.ts = ts; v.rp = rp; v.ri = ri; v.sv = sv; v.zli = zli;
    v.icw4 = icw4; v.ocw2 = ocw2; v.sack = sack; v.chg = chg;
    v.e_isr = e_isr; v.e_int = e_int; v.e_ridx = e_ridx; v.e_rv = e_rv; v.e_db = e_db;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    toSet = v.ts; readPriority = v.rp; readIsr = v.ri; sendVector = v.sv;
    zeroLevelIndex = v.zli; ICW4 = v.icw4; OCW2 = v.ocw2;
    secondACK = v.sack; changeInOCW2 = v.chg;
    @(posedge clk);
    #1;
    chk("isrRegValue", idx, isrRegValue, v.e_isr);
    chk("INTIndex", idx, {5'b0, INTIndex}, {5'b0, v.e_int});
    chk("resetedIndex", idx, {5'b0, resetedIndex}, {5'b0, v.e_ridx});
    chk("resetedValid", idx, {7'b0, resetedValid}, {7'b0, v.e_rv});
    chk("dataBuffer", idx, dataBuffer, v.e_db);
  endtask

  task automatic idle_inputs();
    toSet = 0; readPriority = 0; readIsr = 0; sendVector = 0; zeroLevelIndex = 0;
    ICW4 = 0; OCW2 = 0; secondACK = 0; changeInOCW2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ICW2 = 8'hAA;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset isr", 0, isrRegValue, 8'h00);
    chk("reset INTIndex", 0, {5'b0, INTIndex}, 8'h00);
    chk("reset resetedIndex", 0, {5'b0, resetedIndex}, 8'h00);
    chk("reset resetedValid", 0, {7'b0, resetedValid}, 8'h00);
    chk("reset dataBuffer", 0, dataBuffer, 8'h00);
    rst_n = 1'b1;

    //                ts rp ri sv zli icw4   ocw2   sk ch  isr    int ridx rv db
    tbl.push_back(mk(3, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h08, 3, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h08, 3, 0, 0, 8'hAB));
    tbl.push_back(mk(5, 1, 0, 0, 0, 8'h02, 8'h00, 0, 0, 8'h28, 5, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h02, 8'h00, 1, 0, 8'h08, 5, 5, 1, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h02, 8'h00, 0, 0, 8'h08, 5, 5, 0, 8'h00));
    tbl.push_back(mk(5, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h28, 5, 5, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h28, 5, 5, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h28, 5, 5, 0, 8'h28));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h20, 0, 1, 8'h20, 5, 3, 1, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h20, 0, 1, 8'h00, 5, 5, 1, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h20, 0, 1, 8'h00, 5, 5, 0, 8'h00));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h02, 1, 5, 0, 8'h00));
    tbl.push_back(mk(7, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h82, 7, 5, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 5, 8'h00, 8'h20, 0, 1, 8'h02, 7, 7, 1, 8'h00));
    tbl.push_back(mk(7, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h82, 7, 7, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hA0, 0, 1, 8'h80, 7, 1, 1, 8'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h81, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h20, 0, 1, 8'h01, 0, 7, 1, 8'h00));
    tbl.push_back(mk(6, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h41, 6, 7, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 7, 8'h00, 8'h20, 0, 1, 8'h40, 6, 0, 1, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 7, 8'h00, 8'h20, 0, 1, 8'h00, 6, 6, 1, 8'h00));
    tbl.push_back(mk(2, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h04, 2, 6, 0, 8'h00));
    tbl.push_back(mk(3, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h0C, 3, 6, 0, 8'h00));
`ifdef ISR_SPECIFIC_EOI_EN
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h63, 0, 1, 8'h04, 3, 3, 1, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h61, 0, 1, 8'h04, 3, 3, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h40, 0, 1, 8'h04, 3, 3, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hE2, 0, 1, 8'h00, 3, 2, 1, 8'h00));
`else
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h63, 0, 1, 8'h0C, 3, 6, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h61, 0, 1, 8'h0C, 3, 6, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h40, 0, 1, 8'h0C, 3, 6, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hE2, 0, 1, 8'h0C, 3, 6, 0, 8'h00));
`endif

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i + 1);

    // readback priority
    do_reset();
    step(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h01, 0, 0, 0, 8'h00), 101);
    step(mk(4, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h11, 4, 0, 0, 8'h00), 102);
    step(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h11, 4, 0, 0, 8'h11), 103);
    step(mk(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h11, 4, 0, 0, 8'hAC), 104);
    step(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h11, 4, 0, 0, 8'h00), 105);

    // same-cycle collisions
    do_reset();
    step(mk(2, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h04, 2, 0, 0, 8'h00), 201);
    step(mk(2, 1, 0, 0, 0, 8'h00, 8'h62, 0, 1, 8'h04, 2, 0, 0, 8'h00), 202);
    step(mk(4, 1, 0, 0, 0, 8'h00, 8'h20, 0, 1, 8'h10, 4, 2, 1, 8'h00), 203);
    step(mk(6, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h50, 6, 2, 0, 8'h00), 204);
    step(mk(0, 0, 0, 0, 0, 8'h02, 8'h20, 1, 1, 8'h00, 6, 6, 1, 8'h00), 205);

    // asynchronous reset mid-cycle while a pulse is high
    #3;
    rst_n = 1'b0;
    idle_inputs();
    sendVector = 1'b1;
    #1;
    chk("async isr", 301, isrRegValue, 8'h00);
    chk("async INTIndex", 301, {5'b0, INTIndex}, 8'h00);
    chk("async resetedIndex", 301, {5'b0, resetedIndex}, 8'h00);
    chk("async resetedValid", 301, {7'b0, resetedValid}, 8'h00);
    chk("async vector", 301, dataBuffer, 8'hA8);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/in_service_register.md
Name: in_service_register

Overview:
- In-Service Register (ISR) block of the 8259A-compatible programmable interrupt controller.
- On the first INTA it marks the winning IRQ level as in service. On the second INTA it supplies the interrupt vector.
- Clears ISR bits on automatic EOI, non-specific EOI or specific EOI, and reports the cleared level to the priority resolver.
- Sits between the priority resolver, the control/ICW-OCW registers and the data bus buffer.

Parameters:
- NUM_LEVELS, 8, number of IRQ levels. Fixed at 8; any other value is unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- toSet  in  3  IRQ level granted by the priority resolver
- readPriority  in  1  first-INTA strobe; set ISR[toSet]
- readIsr  in  1  OCW3 read-ISR select; drive ISR onto dataBuffer
- sendVector  in  1  second-INTA strobe; drive vector onto dataBuffer
- zeroLevelIndex  in  3  level currently holding highest priority (rotation base)
- ICW2  in  8  vector base; bits [7:3] used
- ICW4  in  8  bit1 = AEOI enable; other bits ignored
- OCW2  in  8  EOI command word; bits [7:5] command, [2:0] level
- secondACK  in  1  end-of-second-INTA strobe; AEOI point
- changeInOCW2  in  1  one-cycle strobe: a new OCW2 was written
- INTIndex  out  3  level latched at last readPriority
- dataBuffer  out  8  vector / ISR readback to data bus buffer
- isrRegValue  out  8  current ISR contents
- resetedIndex  out  3  level most recently cleared
- resetedValid  out  1  one-cycle pulse when an ISR bit was cleared

Behaviour:
- Reset (async, rst_n=0): ISR=8'h00, INTIndex=0, resetedIndex=0, resetedValid=0.
- readPriority=1 at clock edge: ISR[toSet]<=1 and INTIndex<=toSet. Visible one cycle later.
- dataBuffer is combinational:
  - sendVector=1: {ICW2[7:3], INTIndex}.
  - else readIsr=1: ISR.
  - else 8'h00.
  - sendVector has priority over readIsr.
- isrRegValue = ISR, registered state, direct.
- AEOI: secondACK=1 and ICW4[1]=1 at edge clears ISR[INTIndex]. secondACK with ICW4[1]=0 has no effect.
- changeInOCW2=1 at edge, decoded on OCW2[7:5]:
  - 001 (non-specific EOI): clear the highest-priority set bit. Search order is zeroLevelIndex, zeroLevelIndex+1, ... mod 8. If ISR==0, nothing is cleared and there is no pulse.
  - 011 (specific EOI): clear ISR[OCW2[2:0]].
  - 101 (rotate on non-specific EOI): same clearing as 001.
  - 111 (rotate on specific EOI): same clearing as 011.
  - Any other code: ISR unchanged.
  - Rotation itself is done by the priority resolver using resetedIndex.
- Every actual clear of a set bit: resetedIndex<=cleared level, resetedValid<=1 for one cycle. Otherwise resetedValid<=0 and resetedIndex holds.
- Clearing a bit that is already 0: no state change, no pulse.
- Simultaneous events in one cycle:
  - Set and clear of different bits: both apply.
  - Set and clear of the same bit: set wins, no pulse.
  - AEOI and OCW2 EOI together: AEOI clear takes precedence for resetedIndex; both bits clear.
- Reset mid-INTA sequence: state returns to reset values immediately. A later sendVector outputs {ICW2[7:3], 3'b000}.

Optional Feature:
- Macro ISR_SPECIFIC_EOI_EN.
- Defined: OCW2 codes 011 and 111 clear the addressed level as above.
- Undefined: codes 011 and 111 are ignored (no clear, no pulse). Only AEOI and non-specific EOI (001/101) clear bits.

Decomposition:
- Shared package pic_pkg holds:
  - OCW2 command code constants (NSEOI=3'b001, SEOI=3'b011, ROT_NSEOI=3'b101, ROT_SEOI=3'b111).
  - ICW4 AEOI bit position constant (1).
  - Level index typedef (3-bit).
- One sub-module is natural: isr_priority_scan. It is combinational and finds the highest-priority set bit given ISR and zeroLevelIndex, with outputs index and found flag.

Test Plan:
- Set/vector: reset; ICW2=8'hAA; toSet=3; readPriority pulse; then sendVector=1 -> isrRegValue=8'h08, INTIndex=3, dataBuffer=8'hAB.
- AEOI: ICW4=8'h02; set level 5; secondACK pulse -> isrRegValue=8'h00, resetedIndex=5, resetedValid pulses once. Repeat with ICW4=8'h00 -> ISR stays 8'h20.
- Non-specific EOI rotation: ISR=8'h82 (levels 1,7); zeroLevelIndex=5; OCW2=8'h20 with changeInOCW2 -> bit7 cleared, ISR=8'h02, resetedIndex=7. With zeroLevelIndex=0 instead -> bit1 cleared.
- Specific EOI: ISR=8'h0C; OCW2=8'h63 -> ISR=8'h04, resetedIndex=3. OCW2=8'h61 (bit1 clear) -> no change, no pulse. Macro undefined -> ISR unchanged.
- Readback priority: ISR=8'h11; readIsr=1 -> dataBuffer=8'h11. readIsr=1 and sendVector=1 -> dataBuffer is the vector. Both 0 -> 8'h00.
- Collision/reset: readPriority toSet=2 and specific EOI for level 2 in same cycle -> bit2 set, no pulse. Assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately.
